// File: rtl/ycfsm_sync_row.sv
// ycfsm_sync_row: a row of LANES independent dual-rail in/match comparators with
// a return-to-empty handshake, a registered row-wide result, sticky per-lane
// protocol-error flags and a saturating counter of row V1 results.
// Dual-rail codes: Vempty=2'b00, V0=2'b01, V1=2'b10, 2'b11 is illegal.
//
// Handshake (per lane): a lane fires when it is in EMPTY and both in and match
// carry legal non-empty codes in the same cycle; the result is registered on
// that edge. The producer must then return both in and match to Vempty before
// the lane re-arms; while either side still holds data the lane stays FULL.
// After reset a lane waits in DRAIN for both sides to be Vempty, so stale data
// can never produce a result.
//
// lane_state is a debug view of each lane FSM (DRAIN=0, EMPTY=1, FULL=2),
// packed two bits per lane like in/out.
module ycfsm_sync_row #(
    parameter int LANES = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2*LANES-1:0]   in,
    input  logic [2*LANES-1:0]   match,
    input  logic                 err_clr,
    output logic [2*LANES-1:0]   out,
    output logic [1:0]           row_out,
    output logic [LANES-1:0]     err,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [2*LANES-1:0]   lane_state
);

    localparam logic [1:0] VEMPTY  = 2'b00;
    localparam logic [1:0] V0      = 2'b01;
    localparam logic [1:0] V1      = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_EMPTY = 2'd1,
        ST_FULL  = 2'd2
    } lane_st_t;

    logic [LANES-1:0] err_set;
    logic [1:0]       row_next;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_st_t   st;
        logic [1:0] li;
        logic [1:0] lm;
        logic [1:0] cap_in;
        logic [1:0] cap_m;
        logic [1:0] out_r;
        logic       illegal;
        logic       changed;

        assign li = in[2*k +: 2];
        assign lm = match[2*k +: 2];

        // An illegal code on either rail, or a held value that changes while
        // the lane is FULL, is a protocol error; the lane freezes for that cycle.
        assign illegal    = (li == ILLEGAL) || (lm == ILLEGAL);
        assign changed    = (st == ST_FULL) &&
                            (((li != VEMPTY) && (li != cap_in)) ||
                             ((lm != VEMPTY) && (lm != cap_m)));
        assign err_set[k] = illegal || changed;

        assign out[2*k +: 2]        = out_r;
        assign lane_state[2*k +: 2] = st;

        // Lane FSM with registered result; holds state on any protocol error.
        always_ff @(posedge clk) begin
            if (reset) begin
                st     <= ST_DRAIN;
                out_r  <= VEMPTY;
                cap_in <= VEMPTY;
                cap_m  <= VEMPTY;
            end else if (!err_set[k]) begin
                case (st)
                    ST_DRAIN: begin
                        out_r <= VEMPTY;
                        if ((li == VEMPTY) && (lm == VEMPTY)) st <= ST_EMPTY;
                    end
                    ST_EMPTY: begin
                        out_r <= VEMPTY;
                        if ((li != VEMPTY) && (lm != VEMPTY)) begin
                            cap_in <= li;
                            cap_m  <= lm;
                            out_r  <= (li == lm) ? V1 : V0;
                            st     <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if ((li == VEMPTY) && (lm == VEMPTY)) begin
                            out_r <= VEMPTY;
                            st    <= ST_DRAIN;
                        end
                    end
                    default: begin
                        out_r <= VEMPTY;
                        st    <= ST_DRAIN;
                    end
                endcase
            end
        end
    end

    // Row result from the registered lane outputs: empty wins, then all-V1 test.
    always_comb begin
        logic any_empty;
        logic all_v1;
        any_empty = 1'b0;
        all_v1    = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (out[2*k +: 2] == VEMPTY) any_empty = 1'b1;
            if (out[2*k +: 2] != V1)     all_v1    = 1'b0;
        end
        if (any_empty)   row_next = VEMPTY;
        else if (all_v1) row_next = V1;
        else             row_next = V0;
    end

    // Register the row result and count Vempty->V1 transitions, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_out   <= VEMPTY;
            match_cnt <= '0;
        end else begin
            row_out <= row_next;
            if ((row_out == VEMPTY) && (row_next == V1) && (match_cnt != {CNT_W{1'b1}}))
                match_cnt <= match_cnt + 1'b1;
        end
    end

    // Sticky error flags; a new error on the same edge as err_clr stays set.
    always_ff @(posedge clk) begin
        if (reset) err <= '0;
        else       err <= (err_clr ? '0 : err) | err_set;
    end

endmodule

// File: tb/tb_ycfsm_sync_row.sv
// Directed bench for ycfsm_sync_row with LANES=2, CNT_W=2.
// Each step drives inputs, pushes the expected post-edge snapshot
// {out, row_out, err, match_cnt} to a queue and clocks once; the scoreboard
// pops and compares after every edge.
module tb_ycfsm_sync_row;

  localparam int LANES = 2;
  localparam int CNT_W = 2;
  localparam int W     = 2*LANES + 2 + LANES + CNT_W;

  localparam logic [1:0] E  = 2'b00;
  localparam logic [1:0] V0 = 2'b01;
  localparam logic [1:0] V1 = 2'b10;
  localparam logic [1:0] IL = 2'b11;

  logic                 clk;
  logic                 reset;
  logic [2*LANES-1:0]   in;
  logic [2*LANES-1:0]   match;
  logic                 err_clr;
  logic [2*LANES-1:0]   out;
  logic [1:0]           row_out;
  logic [LANES-1:0]     err;
  logic [CNT_W-1:0]     match_cnt;
  logic [2*LANES-1:0]   lane_state;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_tests;
  int           n_fail;
  logic [CNT_W-1:0] exp_cnt;

  ycfsm_sync_row #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .match      (match),
    .err_clr    (err_clr),
    .out        (out),
    .row_out    (row_out),
    .err        (err),
    .match_cnt  (match_cnt),
    .lane_state (lane_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  always @(posedge clk) begin
    logic [W-1:0] expv;
    logic [W-1:0] obs;
    string        tag;
    #1;
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      tag  = tag_q.pop_front();
      obs  = {out, row_out, err, match_cnt};
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $error("FAIL %s: out/row/err/cnt got %b_%b_%b_%b want %b_%b_%b_%b", tag,
               obs[W-1 -: 4], obs[W-5 -: 2], obs[W-7 -: 2], obs[CNT_W-1:0],
               expv[W-1 -: 4], expv[W-5 -: 2], expv[W-7 -: 2], expv[CNT_W-1:0]);
      end
    end
  end

  // driver: one cycle of stimulus, expected snapshot after the edge
  task automatic step(input string tag, input logic rst, input logic clr,
                      input logic [1:0] i1, input logic [1:0] i0,
                      input logic [1:0] m1, input logic [1:0] m0,
                      input logic [3:0] e_out, input logic [1:0] e_row,
                      input logic [1:0] e_err, input logic [CNT_W-1:0] e_cnt);
    reset   = rst;
    err_clr = clr;
    in      = {i1, i0};
    match   = {m1, m0};
    exp_q.push_back({e_out, e_row, e_err, e_cnt});
    tag_q.push_back(tag);
    @(posedge clk);
    #2;
  endtask

  task automatic check_state(input string tag, input logic [2*LANES-1:0] e_st);
    n_tests++;
    if (lane_state !== e_st) begin
      n_fail++;
      $error("FAIL %s: lane_state got %b want %b", tag, lane_state, e_st);
    end
  endtask

  initial begin
    logic [1:0] v0;
    logic [1:0] v1;
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = '0;
    reset   = 1'b1;
    err_clr = 1'b0;
    in      = '0;
    match   = '0;
    @(posedge clk);
    #2;

    // 1: reset with lane0 holding V1/V1; no firing until both sides empty
    step("rst_hold",   1, 0, E, V1, E, V1, 4'b0000, E, 2'b00, 0);
    check_state("rst_state", 4'b0000);
    step("drain_a",    0, 0, E, V1, E, V1, 4'b0000, E, 2'b00, 0);
    step("drain_b",    0, 0, E, V1, E, V1, 4'b0000, E, 2'b00, 0);
    step("drain_empty",0, 0, E, E,  E, E,  4'b0000, E, 2'b00, 0);
    check_state("armed_state", 4'b0101);
    step("fire_after", 0, 0, E, V1, E, V1, 4'b0010, E, 2'b00, 0);
    step("fire_hold",  0, 0, E, V1, E, V1, 4'b0010, E, 2'b00, 0);
    step("t1_clr",     0, 0, E, E,  E, E,  4'b0000, E, 2'b00, 0);
    step("t1_rearm",   0, 0, E, E,  E, E,  4'b0000, E, 2'b00, 0);

    // 2: lane0 V1==V1 -> V1, lane1 V0 vs V1 -> V0; row V0 one clock later
    step("mixed_out",  0, 0, V0, V1, V1, V1, 4'b0110, E,  2'b00, 0);
    step("mixed_row",  0, 0, V0, V1, V1, V1, 4'b0110, V0, 2'b00, 0);
    step("t2_clr",     0, 0, E, E, E, E,     4'b0000, V0, 2'b00, 0);
    step("t2_rearm",   0, 0, E, E, E, E,     4'b0000, E,  2'b00, 0);

    // 3: five matching passes; counter saturates at 3 with CNT_W=2
    for (int p = 0; p < 5; p++) begin
      v0 = ($urandom_range(0, 1) == 0) ? V0 : V1;
      v1 = ($urandom_range(0, 1) == 0) ? V0 : V1;
      step("pass_fire", 0, 0, v1, v0, v1, v0, 4'b1010, E, 2'b00, exp_cnt);
      if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      step("pass_row",  0, 0, E, E, E, E, 4'b0000, V1, 2'b00, exp_cnt);
      step("pass_idle", 0, 0, E, E, E, E, 4'b0000, E,  2'b00, exp_cnt);
    end

    // 4: held value changes while FULL -> sticky err, out unchanged
    step("t4_fire",    0, 0, E, V1, E, V1, 4'b0010, E, 2'b00, exp_cnt);
    step("t4_change",  0, 0, E, V0, E, V1, 4'b0010, E, 2'b01, exp_cnt);
    step("t4_clr_in",  0, 0, E, E,  E, E,  4'b0000, E, 2'b01, exp_cnt);
    step("t4_sticky",  0, 0, E, E,  E, E,  4'b0000, E, 2'b01, exp_cnt);
    step("t4_errclr",  0, 1, E, E,  E, E,  4'b0000, E, 2'b00, exp_cnt);

    // 5: illegal code on lane1 in EMPTY; lane0 fires normally
    step("t5_illegal", 0, 0, IL, V1, E, V1, 4'b0010, E, 2'b10, exp_cnt);
    step("t5_clr_in",  0, 0, E, E, E, E,    4'b0000, E, 2'b10, exp_cnt);
    step("t5_rearm",   0, 0, E, E, E, E,    4'b0000, E, 2'b10, exp_cnt);
    // err_clr on the same edge as a new lane0 error: lane1 clears, lane0 sets
    step("clr_vs_set", 0, 1, E, IL, E, E,   4'b0000, E, 2'b01, exp_cnt);
    step("t5_errclr",  0, 1, E, E, E, E,    4'b0000, E, 2'b00, exp_cnt);

    // 6: one side early for 4 clocks, result one clock after match arrives
    for (int c = 0; c < 4; c++)
      step("t6_wait", 0, 0, E, V1, E, E, 4'b0000, E, 2'b00, exp_cnt);
    step("t6_fire",    0, 0, E, V1, E, V1, 4'b0010, E, 2'b00, exp_cnt);

    // reset mid-handshake clears everything, then lane waits for empty
    step("mid_reset",  1, 0, E, V1, E, V1, 4'b0000, E, 2'b00, 0);
    step("post_reset", 0, 0, E, V1, E, V1, 4'b0000, E, 2'b00, 0);
    step("post_empty", 0, 0, E, E,  E, E,  4'b0000, E, 2'b00, 0);
    step("post_fire",  0, 0, V1, V0, V1, V0, 4'b1010, E, 2'b00, 0);
    step("post_row",   0, 0, E, E,  E, E,  4'b0000, V1, 2'b00, 1);

    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
